hilo_muldiv: RTL and testbench

- Iterative multiply/divide unit in the execute stage, directly downstream of instruction decode.
- Consumes the decoded aluop plus the rA/rB operand values and owns the architectural HI/LO registers.
- Serves MFHI/MFLO reads and raises a pipeline interlock while an operation is in flight.
- Decode collapses MULT/MULTU and DIV/DIVU onto shared aluops, so signedness arrives on a separate input.

---
 rtl/hilo_muldiv.sv | 172 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring step per cycle, sign fix-up on the final edge.
module hilo_muldiv #(
    parameter logic [5:0] MULT_OP = 6'b000010,
    parameter logic [5:0] DIV_OP  = 6'b000011,
    parameter logic [5:0] MFHI_OP = 6'b000100,
    parameter logic [5:0] MFLO_OP = 6'b000101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [5:0]  aluop,
    input  logic        is_signed,
    input  logic [31:0] rA,
    input  logic [31:0] rB,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        divz_q, divz_d;
    logic [31:0] raw_a_q, raw_a_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        start;
    logic        muldiv_op;
    logic [31:0] add;
    logic [32:0] msum;
    logic [32:0] rshift;
    logic [31:0] diff;
    logic        ge;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;

    assign muldiv_op = (aluop == MULT_OP) || (aluop == DIV_OP);
    assign start     = valid && muldiv_op;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        raw_a_d   = raw_a_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = (state_q == FIX);

        add    = b_q[0] ? a_q : 32'd0;
        msum   = {1'b0, acc_q[63:32]} + {1'b0, add};
        rshift = {acc_q[63:32], a_q[31]};
        ge     = (rshift >= {1'b0, b_q});
        // Remainder after a successful subtract always fits in 32 bits
        diff   = rshift[31:0] - b_q;
        prod   = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        quo    = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem    = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    count_d   = 5'd0;
                    is_div_d  = (aluop == DIV_OP);
                    neg_res_d = is_signed && (rA[31] ^ rB[31]);
                    neg_rem_d = is_signed && rA[31];
                    divz_d    = (rB == 32'd0);
                    raw_a_d   = rA;
                    a_d       = (is_signed && rA[31]) ? (~rA + 32'd1) : rA;
                    b_d       = (is_signed && rB[31]) ? (~rB + 32'd1) : rB;
                    acc_d     = 64'd0;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_d = {(ge ? diff : rshift[31:0]), acc_q[30:0], ge};
                    a_d   = {a_q[30:0], 1'b0};
                end else begin
                    acc_d = {msum, acc_q[31:1]};
                    b_d   = {1'b0, b_q[31:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!is_div_q) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (divz_q) begin
                    hi_d = raw_a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            raw_a_q   <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            raw_a_q   <= raw_a_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy && valid &&
                   (muldiv_op || aluop == MFHI_OP || aluop == MFLO_OP);

    always_comb begin
        mf_data = 32'd0;
        if (aluop == MFHI_OP) begin
            mf_data = hi_q;
        end else if (aluop == MFLO_OP) begin
            mf_data = lo_q;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO queued at issue,
// popped and compared when the done pulse arrives.
module tb_hilo_muldiv;

    localparam logic [5:0] MULT = 6'b000010;
    localparam logic [5:0] DIV  = 6'b000011;
    localparam logic [5:0] MFHI = 6'b000100;
    localparam logic [5:0] MFLO = 6'b000101;
    localparam logic [5:0] ADD  = 6'b000001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [5:0]  aluop = 6'd0;
    logic        is_signed = 1'b0;
    logic [31:0] rA = 32'd0;
    logic [31:0] rB = 32'd0;
    logic        busy, done, stall;
    logic [31:0] hi, lo, mf_data;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    hilo_muldiv dut (
        .clock(clock), .reset(reset), .valid(valid), .aluop(aluop),
        .is_signed(is_signed), .rA(rA), .rB(rB), .busy(busy),
        .done(done), .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clock = ~clock;

    task automatic issue(input logic [5:0] op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
        if (push) exp_q.push_back(exp);
        @(negedge clock);
        valid = 1'b1; aluop = op; is_signed = sgn; rA = a; rB = b;
        @(posedge clock);
        #1;
        valid = 1'b0; aluop = 6'd0;
    endtask

    // Waits for done, counting busy cycles, then pops the expected result
    task automatic finish_op(input string name);
        int n;
        bit got;
        logic [63:0] exp;
        n = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1;
                break;
            end
            if (busy) n++;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_done: no done pulse within 40 cycles", name);
        end
        n_chk++;
        if (n !== 33) begin
            n_fail++;
            $display("FAIL %s_busy: busy cycles %0d, required 33", name, n);
        end
        exp = exp_q.pop_front();
        n_chk++;
        if ({hi, lo} !== exp) begin
            n_fail++;
            $display("FAIL %s_hilo: got %h_%h, required %h_%h",
                     name, hi, lo, exp[63:32], exp[31:0]);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_fall: busy=%b in done cycle", name, busy);
        end
        @(negedge clock);
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_chk++;
        if ({busy, done, stall} !== 3'b000 || hi !== 0 || lo !== 0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b stall=%b hi=%h lo=%h",
                     busy, done, stall, hi, lo);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mult();
        issue(MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1);
        finish_op("smul");
        issue(MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001, 1);
        finish_op("umul");
    endtask

    task automatic test_div();
        issue(DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        finish_op("sdiv");
        issue(DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              64'h0000_0000_8000_0000, 1);
        finish_op("sdiv_ovf");
        issue(DIV, 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1);
        finish_op("udiv");
        issue(DIV, 1'b0, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1);
        finish_op("div0");
    endtask

    task automatic test_mf();
        @(negedge clock);
        valid = 1'b1; aluop = MFHI;
        #1;
        n_chk++;
        if (mf_data !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mfhi: got %h, required 00001234", mf_data);
        end
        aluop = MFLO;
        #1;
        n_chk++;
        if (mf_data !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL mflo: got %h, required ffffffff", mf_data);
        end
        aluop = ADD;
        #1;
        n_chk++;
        if (mf_data !== 32'd0) begin
            n_fail++;
            $display("FAIL mf_other: got %h, required 0", mf_data);
        end
        valid = 1'b0;
    endtask

    task automatic test_interlock();
        int bad;
        bit got;
        issue(MULT, 1'b0, 32'd3, 32'd5, 64'd15, 1);
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (stall !== 1'b0) bad++;
        end
        valid = 1'b1; aluop = ADD;
        @(negedge clock);
        if (stall !== 1'b0) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_idle_ops: %0d cycles stalled, required 0", bad);
        end
        aluop = MFLO;
        bad = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1;
                break;
            end
            if (stall !== 1'b1) bad++;
        end
        n_chk++;
        if (!got || bad != 0) begin
            n_fail++;
            $display("FAIL interlock: done=%b, %0d cycles unstalled", got, bad);
        end
        n_chk++;
        if (stall !== 1'b0 || mf_data !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL mflo_done: stall=%b mf_data=%h, required 0/0000000f",
                     stall, mf_data);
        end
        void'(exp_q.pop_front());
        valid = 1'b0; aluop = 6'd0;
    endtask

    task automatic test_back_to_back();
        int bad;
        bit got;
        issue(MULT, 1'b0, 32'd6, 32'd7, 64'd42, 1);
        exp_q.push_back(64'd81);
        valid = 1'b1; aluop = MULT; is_signed = 1'b0; rA = 32'd9; rB = 32'd9;
        bad = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1;
                break;
            end
            if (stall !== 1'b1) bad++;
        end
        n_chk++;
        if (!got || bad != 0) begin
            n_fail++;
            $display("FAIL b2b_hold: done=%b, %0d unstalled cycles", got, bad);
        end
        n_chk++;
        if ({hi, lo} !== exp_q.pop_front() || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: hilo=%h_%h stall=%b, required 42 / 0",
                     hi, lo, stall);
        end
        @(posedge clock);
        #1;
        valid = 1'b0; aluop = 6'd0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b after done edge, required 1", busy);
        end
        finish_op("b2b_second");
    endtask

    task automatic test_reset_midop();
        issue(DIV, 1'b0, 32'd100, 32'd7, 64'd0, 0);
        repeat (11) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        n_chk++;
        if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
            n_fail++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h",
                     busy, done, hi, lo);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b after release", busy);
        end
        issue(MULT, 1'b0, 32'd2, 32'd2, 64'd4, 1);
        finish_op("post_reset_mul");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mf();
        test_interlock();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
